cache_tag_array: RTL
====================

// Module: cache_tag_array
// PURPOSE
//  Parametrised N-way set-associative tag store for the I/D caches.
//  - Per set, per way: tag, valid, dirty. Per set: round-robin victim pointer.
//  - Registered tag compare produces a per-way hit vector.
//  - Self-clearing invalidate sweep after reset and on flush request.
//  - Sits between the cache controller FSM and its tag BRAMs.
// PARAMETERS
//  WAYS       2   number of ways, power of 2, range 1..8
//  SETS_LOG2  7   log2 of set count; address width
//  TAG_WIDTH  21  tag bits per way
//  Derived: VW = (WAYS>1) ? $clog2(WAYS) : 1
// PORTS
//  clk       in   1                clock; all logic on posedge
//  rst       in   1                synchronous active-high reset
//  flush     in   1                pulse: start invalidate sweep
//  busy      out  1                sweep in progress; re/we ignored
//  re        in   1                read/lookup request
//  raddr     in   SETS_LOG2        set index for lookup
//  rtag      in   TAG_WIDTH        tag to compare
//  rd_valid  out  1                lookup result valid
//  rd_tag    out  WAYS*TAG_WIDTH   stored tags; way i at [i*TAG_WIDTH +: TAG_WIDTH]
//  rd_vld    out  WAYS             per-way valid bits
//  rd_dirty  out  WAYS             per-way dirty bits
//  hit       out  WAYS             per-way hit = rd_vld[i] & tag match
//  hit_any   out  1                OR of hit
//  victim    out  VW               victim way for the looked-up set
//  we        in   WAYS             per-way write enable
//  waddr     in   SETS_LOG2        set index for write
//  wtag      in   TAG_WIDTH        tag written to every enabled way
//  wvalid    in   1                valid bit written
//  wdirty    in   1                dirty bit written
// BEHAVIOUR
//  - States: INIT, READY. rst -> INIT with sweep counter = 0.
//  - INIT: each cycle write tag=0, valid=0, dirty=0, victim=0 to set[counter] in all ways.
//    Counter increments; at 2^SETS_LOG2-1 go to READY next cycle. Sweep takes exactly
//    2^SETS_LOG2 cycles. busy=1 in INIT only.
//  - READY + flush -> INIT, counter=0. flush during INIT restarts counter at 0.
//    rst during sweep restarts the sweep. Behaviour of rst mid-operation is identical.
//  - Reset values: busy=1, rd_valid=0, hit=0, hit_any=0, victim=0, rd_* = 0.
//  - Lookup (READY, re=1 at cycle N):
//    - rd_valid=1 in cycle N+1; all rd_*, hit and victim reflect raddr/rtag sampled at N.
//    - Outputs hold until the next accepted re. rd_valid is high only in N+1.
//    - re while busy: dropped; rd_valid stays 0.
//  - Write (READY, |we):
//    - For each i with we[i]=1, set[waddr].way[i] <= {wtag, wvalid, wdirty}.
//    - Ways with we[i]=0 are untouched.
//    - |we also advances victim[waddr] by 1, mod WAYS. Wrap WAYS-1 -> 0.
//    - WAYS=1: victim is always 0.
//    - we while busy: dropped.
//  - Same-cycle re and |we, raddr==waddr: see TAG_BYPASS_EN. Different sets are fully independent.
//  - Tag compare is full-width equality. hit bits are one-hot unless software wrote duplicate
//    tags; no priority encoding is done here.
// CONFIGURATION
//  TAG_BYPASS_EN defined: write-first forwarding on a same-set collision.
//    - Written ways return the new tag/valid/dirty in N+1; hit uses the new values.
//    - victim returns the advanced pointer.
//  TAG_BYPASS_EN undefined: read-first.
//    - Returns pre-write contents and the pre-write victim.
//    - New data is visible from the next lookup.
// TESTING
//  - rst 1 cycle, SETS_LOG2=7 -> busy high exactly 128 cycles. Then lookup every set
//    -> rd_vld=0, hit_any=0, victim=0.
//  - WAYS=2: we=2'b01, waddr=5, wtag=0x1ABCD, wvalid=1, wdirty=0; next cycle re raddr=5
//    rtag=0x1ABCD -> rd_valid=1, hit=2'b01, rd_dirty=0, victim=1.
//  - WAYS=4: four writes to set 9 -> victim 1,2,3,0 (wrap). Lookup with mismatching
//    rtag -> hit_any=0, tags intact.
//  - Same cycle: re=1, we=2'b10, raddr=waddr=3, wtag=0x7 -> TAG_BYPASS_EN: hit[1]=1;
//    without: hit[1]=0. Next lookup: hit[1]=1 in both builds.
//  - Populate sets 0..3, pulse flush; at sweep cycle 40 assert flush again
//    -> busy lasts 40+128 cycles total. re/we ignored meanwhile. All valid=0 afterwards.
//  - rst asserted mid-sweep and mid-lookup -> rd_valid=0 next cycle, full 128-cycle sweep restarts.

Source files
------------

// File: rtl/cache_tag_array.sv
// N-way set-associative tag store: per-way tag/valid/dirty, per-set round-robin victim,
// registered lookup with hit vector, invalidate sweep. Optional macro: TAG_BYPASS_EN.
module cache_tag_array #(
  parameter int WAYS      = 2,
  parameter int SETS_LOG2 = 7,
  parameter int TAG_WIDTH = 21,
  localparam int VW       = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  output logic                      busy,
  input  logic                      re,
  input  logic [SETS_LOG2-1:0]      raddr,
  input  logic [TAG_WIDTH-1:0]      rtag,
  output logic                      rd_valid,
  output logic [WAYS*TAG_WIDTH-1:0] rd_tag,
  output logic [WAYS-1:0]           rd_vld,
  output logic [WAYS-1:0]           rd_dirty,
  output logic [WAYS-1:0]           hit,
  output logic                      hit_any,
  output logic [VW-1:0]             victim,
  input  logic [WAYS-1:0]           we,
  input  logic [SETS_LOG2-1:0]      waddr,
  input  logic [TAG_WIDTH-1:0]      wtag,
  input  logic                      wvalid,
  input  logic                      wdirty
);

  localparam int SETS = 1 << SETS_LOG2;

  typedef enum logic {INIT, READY} state_t;

  state_t                 state_q, state_d;
  logic [SETS_LOG2-1:0]   cnt_q, cnt_d;

  logic [TAG_WIDTH-1:0]   tag_mem   [SETS][WAYS];
  logic [WAYS-1:0]        vld_mem   [SETS];
  logic [WAYS-1:0]        dirty_mem [SETS];
  logic [VW-1:0]          vic_mem   [SETS];

  logic                      rd_valid_q, rd_valid_d;
  logic [WAYS*TAG_WIDTH-1:0] rd_tag_q, rd_tag_d;
  logic [WAYS-1:0]           rd_vld_q, rd_vld_d;
  logic [WAYS-1:0]           rd_dirty_q, rd_dirty_d;
  logic [WAYS-1:0]           hit_q, hit_d;
  logic [VW-1:0]             victim_q, victim_d;

  logic          re_ok;
  logic          we_ok;
  logic [VW-1:0] vic_wr_nxt;

  assign re_ok      = (state_q == READY) && re;
  assign we_ok      = (state_q == READY) && (|we);
  assign vic_wr_nxt = (WAYS == 1) ? '0 : vic_mem[waddr] + VW'(1);

  // Sweep walks every set once; a flush at any time restarts it from set 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + SETS_LOG2'(1);
        if (flush) begin
          cnt_d = '0;
        end else if (&cnt_q) begin
          state_d = READY;
        end
      end
      READY: begin
        if (flush) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == INIT) begin
        for (int i = 0; i < WAYS; i++) begin
          tag_mem[cnt_q][i] <= '0;
        end
        vld_mem[cnt_q]   <= '0;
        dirty_mem[cnt_q] <= '0;
        vic_mem[cnt_q]   <= '0;
      end else if (we_ok) begin
        for (int i = 0; i < WAYS; i++) begin
          if (we[i]) begin
            tag_mem[waddr][i]   <= wtag;
            vld_mem[waddr][i]   <= wvalid;
            dirty_mem[waddr][i] <= wdirty;
          end
        end
        vic_mem[waddr] <= vic_wr_nxt;
      end
    end
  end

`ifdef TAG_BYPASS_EN
  logic collide;
  assign collide = re_ok && we_ok && (raddr == waddr);
`endif

  // Lookup results are held between accepted reads; rd_valid pulses for one cycle.
  always_comb begin
    logic [TAG_WIDTH-1:0] t;
    logic                 v;
    logic                 d;
    t          = '0;
    v          = 1'b0;
    d          = 1'b0;
    rd_valid_d = 1'b0;
    rd_tag_d   = rd_tag_q;
    rd_vld_d   = rd_vld_q;
    rd_dirty_d = rd_dirty_q;
    hit_d      = hit_q;
    victim_d   = victim_q;
    if (re_ok) begin
      rd_valid_d = 1'b1;
      for (int i = 0; i < WAYS; i++) begin
        t = tag_mem[raddr][i];
        v = vld_mem[raddr][i];
        d = dirty_mem[raddr][i];
`ifdef TAG_BYPASS_EN
        if (collide && we[i]) begin
          t = wtag;
          v = wvalid;
          d = wdirty;
        end
`endif
        rd_tag_d[i*TAG_WIDTH +: TAG_WIDTH] = t;
        rd_vld_d[i]                        = v;
        rd_dirty_d[i]                      = d;
        hit_d[i]                           = v && (t == rtag);
      end
      victim_d = vic_mem[raddr];
`ifdef TAG_BYPASS_EN
      if (collide) begin
        victim_d = vic_wr_nxt;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_tag_q   <= '0;
      rd_vld_q   <= '0;
      rd_dirty_q <= '0;
      hit_q      <= '0;
      victim_q   <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_tag_q   <= rd_tag_d;
      rd_vld_q   <= rd_vld_d;
      rd_dirty_q <= rd_dirty_d;
      hit_q      <= hit_d;
      victim_q   <= victim_d;
    end
  end

  assign busy     = (state_q == INIT);
  assign rd_valid = rd_valid_q;
  assign rd_tag   = rd_tag_q;
  assign rd_vld   = rd_vld_q;
  assign rd_dirty = rd_dirty_q;
  assign hit      = hit_q;
  assign hit_any  = |hit_q;
  assign victim   = victim_q;

endmodule
